// File: rtl/register_read_port.sv
// Read-side front end for the register bank: valid/ready requests in, 1-cycle bank read,
// buffered in-order responses out, with out-of-range addresses answered locally as errors.
module register_read_port #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              bank_ren,
    output logic [ADDR_W-1:0] bank_raddr,
    input  logic [WIDTH-1:0]  bank_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = WIDTH + 1;

    // Each entry is {err, data}.
    logic [ENT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_inc;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             inflight;
    logic             inflight_err;
    logic             addr_ok;
    logic             accept;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] push_entry;
    logic [ENT_W-1:0] head_next;

    // Credit check counts the read still in flight so the push next cycle always has room.
    always_comb begin
        req_ready  = !rst && ((32'(count) + 32'(inflight)) < DEPTH);
        addr_ok    = 32'(req_addr) < NUM_REGS;
        accept     = req_valid && req_ready;
        bank_ren   = accept && addr_ok;
        bank_raddr = req_addr;
    end

    always_comb begin
        wr_ptr_inc = (32'(wr_ptr) == DEPTH - 1) ? '0 : wr_ptr + PTR_W'(1);
        rd_ptr_inc = (32'(rd_ptr) == DEPTH - 1) ? '0 : rd_ptr + PTR_W'(1);
        push       = inflight;
        pop        = rsp_valid && rsp_ready;
        push_entry = inflight_err ? {1'b1, WIDTH'(0)} : {1'b0, bank_rdata};
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Next head: next stored entry on pop, or the incoming push when it lands at the head.
    always_comb begin
        head_next = {rsp_err, rsp_data};
        if (pop) begin
            if (count > CNT_W'(1)) begin
                head_next = mem[rd_ptr_inc];
            end else if (push) begin
                head_next = push_entry;
            end
        end else if ((count == '0) && push) begin
            head_next = push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            inflight     <= 1'b0;
            inflight_err <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            count        <= count_next;
            inflight     <= accept;
            inflight_err <= accept && !addr_ok;
            rsp_valid    <= (count_next != '0);
            {rsp_err, rsp_data} <= head_next;
            if (push) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: tb/tb_register_read_port.sv
// Randomised and directed bench for register_read_port against a queue-based reference model.
module tb_register_read_port;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned DEPTH    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              bank_ren;
    logic [ADDR_W-1:0] bank_raddr;
    logic [WIDTH-1:0]  bank_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_err;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int          cyc    = 0;

    logic [WIDTH-1:0] bank [32];

    // Every outstanding read, in order, tagged with the cycle it was accepted.
    typedef struct {
        logic [WIDTH-1:0] d;
        logic             e;
        int               cyc;
    } exp_t;
    exp_t q[$];

    register_read_port #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .bank_ren(bank_ren), .bank_raddr(bank_raddr), .bank_rdata(bank_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bank_ren) bank_rdata <= bank[bank_raddr];
    end

    function automatic logic m_ready();
        return !rst && (q.size() < int'(DEPTH));
    endfunction

    function automatic logic m_valid();
        return (q.size() != 0) && (q[0].cyc + 2 <= cyc);
    endfunction

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic rr);
        req_valid = v;
        req_addr  = a;
        rsp_ready = rr;
        @(negedge clk);
    endtask

    // Advance the model by one cycle, then move to just after the next rising edge.
    task automatic end_cycle();
        logic acc;
        logic pop;
        exp_t e;
        acc = req_valid && m_ready();
        pop = m_valid() && rsp_ready;
        if (rst) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.e   = (32'(req_addr) >= NUM_REGS);
                e.d   = e.e ? '0 : bank[req_addr];
                e.cyc = cyc;
                q.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 5'd3, 1'b0);
        end_cycle();
        drive(1'b1, 5'd3, 1'b0);
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passed++;
        total++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else passed++;
        total++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", rsp_err); else passed++;
        total++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else passed++;
        total++; if (bank_ren !== 1'b0) $display("FAIL reset_bank_ren: got %b want 0", bank_ren); else passed++;
        end_cycle();
        rst = 1'b0;
        drive(1'b0, 5'd0, 1'b0);
        total++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready); else passed++;
        end_cycle();
    endtask

    task automatic test_single();
        bank[3] = 32'hFFFF0000;
        drive(1'b1, 5'd3, 1'b1);
        total++; if (bank_ren !== 1'b1) $display("FAIL single_ren: got %b want 1", bank_ren); else passed++;
        total++; if (bank_raddr !== 5'd3) $display("FAIL single_raddr: got %0d want 3", bank_raddr); else passed++;
        end_cycle();
        drive(1'b0, 5'd0, 1'b1);
        total++; if (rsp_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", rsp_valid); else passed++;
        end_cycle();
        drive(1'b0, 5'd0, 1'b1);
        total++; if (rsp_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", rsp_valid); else passed++;
        total++; if (rsp_data !== 32'hFFFF0000) $display("FAIL single_data: got %h want ffff0000", rsp_data); else passed++;
        total++; if (rsp_err !== 1'b0) $display("FAIL single_err: got %b want 0", rsp_err); else passed++;
        end_cycle();
        drive(1'b0, 5'd0, 1'b1);
        total++; if (rsp_valid !== 1'b0) $display("FAIL single_after_pop: got %b want 0", rsp_valid); else passed++;
        end_cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(i < 4, 5'(i), 1'b1);
            if (i < 4) begin
                total++; if (req_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); else passed++;
            end
            total++; if (rsp_valid !== (i >= 2 && i <= 5)) $display("FAIL b2b_valid[%0d]: got %b", i, rsp_valid); else passed++;
            if (i >= 2 && i <= 5) begin
                total++;
                if ({rsp_err, rsp_data} !== {1'b0, bank[i-2]})
                    $display("FAIL b2b_data[%0d]: got %b/%h want 0/%h", i, rsp_err, rsp_data, bank[i-2]);
                else passed++;
            end
            end_cycle();
        end
    endtask

    task automatic test_backpressure();
        int accepted;
        int issued;
        int got;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 5'(8 + i), 1'b0);
            total++; if (req_ready !== (i < 4)) $display("FAIL bp_ready[%0d]: got %b want %b", i, req_ready, i < 4); else passed++;
            if (req_ready) accepted++;
            end_cycle();
        end
        total++; if (accepted != 4) $display("FAIL bp_accepted: got %0d want 4", accepted); else passed++;
        issued = 4;
        got    = 0;
        for (int i = 0; i < 30 && got < 6; i++) begin
            drive(issued < 6, 5'(8 + issued), 1'b1);
            total++; if (req_ready !== m_ready()) $display("FAIL bp_drain_ready[%0d]: got %b want %b", i, req_ready, m_ready()); else passed++;
            if (rsp_valid) begin
                total++;
                if ({rsp_err, rsp_data} !== {1'b0, bank[8 + got]})
                    $display("FAIL bp_data[%0d]: got %b/%h want 0/%h", got, rsp_err, rsp_data, bank[8 + got]);
                else passed++;
                got++;
            end
            if (req_valid && req_ready) issued++;
            end_cycle();
        end
        total++; if (got != 6) $display("FAIL bp_drain_count: got %0d want 6", got); else passed++;
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 5'd20, 1'b1);
        total++; if (bank_ren !== 1'b0) $display("FAIL oor_ren20: got %b want 0", bank_ren); else passed++;
        end_cycle();
        drive(1'b1, 5'd7, 1'b1);
        total++; if (bank_ren !== 1'b1) $display("FAIL oor_ren7: got %b want 1", bank_ren); else passed++;
        end_cycle();
        drive(1'b1, 5'd16, 1'b1);
        total++; if (bank_ren !== 1'b0) $display("FAIL oor_ren16: got %b want 0", bank_ren); else passed++;
        total++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 32'h0})
            $display("FAIL oor_rsp20: got %b/%b/%h want 1/1/0", rsp_valid, rsp_err, rsp_data); else passed++;
        end_cycle();
        drive(1'b1, 5'd15, 1'b1);
        total++; if (bank_ren !== 1'b1) $display("FAIL oor_ren15: got %b want 1", bank_ren); else passed++;
        total++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, bank[7]})
            $display("FAIL oor_rsp7: got %b/%b/%h want 1/0/%h", rsp_valid, rsp_err, rsp_data, bank[7]); else passed++;
        end_cycle();
        drive(1'b0, 5'd0, 1'b1);
        total++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 32'h0})
            $display("FAIL oor_rsp16: got %b/%b/%h want 1/1/0", rsp_valid, rsp_err, rsp_data); else passed++;
        end_cycle();
        drive(1'b0, 5'd0, 1'b1);
        total++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, bank[15]})
            $display("FAIL oor_rsp15: got %b/%b/%h want 1/0/%h", rsp_valid, rsp_err, rsp_data, bank[15]); else passed++;
        end_cycle();
        drive(1'b0, 5'd0, 1'b1);
        total++; if (rsp_valid !== 1'b0) $display("FAIL oor_idle: got %b want 0", rsp_valid); else passed++;
        end_cycle();
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 5'd5, 1'b1);
        total++; if (bank_ren !== 1'b1) $display("FAIL mid_ren: got %b want 1", bank_ren); else passed++;
        end_cycle();
        rst = 1'b1;
        drive(1'b0, 5'd0, 1'b1);
        end_cycle();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 5'd0, 1'b1);
            total++; if (rsp_valid !== 1'b0) $display("FAIL mid_valid[%0d]: got %b want 0", i, rsp_valid); else passed++;
            end_cycle();
        end
    endtask

    task automatic test_random();
        logic exp_ren;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0);
            exp_ren = req_valid && m_ready() && (32'(req_addr) < NUM_REGS);
            total++; if (req_ready !== m_ready()) $display("FAIL rand_ready@%0d: got %b want %b", cyc, req_ready, m_ready()); else passed++;
            total++; if (bank_ren !== exp_ren) $display("FAIL rand_ren@%0d: got %b want %b", cyc, bank_ren, exp_ren); else passed++;
            if (exp_ren) begin
                total++; if (bank_raddr !== req_addr) $display("FAIL rand_raddr@%0d: got %0d want %0d", cyc, bank_raddr, req_addr); else passed++;
            end
            total++; if (rsp_valid !== m_valid()) $display("FAIL rand_valid@%0d: got %b want %b", cyc, rsp_valid, m_valid()); else passed++;
            if (m_valid()) begin
                total++;
                if ({rsp_err, rsp_data} !== {q[0].e, q[0].d})
                    $display("FAIL rand_data@%0d: got %b/%h want %b/%h", cyc, rsp_err, rsp_data, q[0].e, q[0].d);
                else passed++;
            end
            end_cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = $urandom;
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_out_of_range();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
